// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scanner: scan FSM encoding and default geometry.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } scan_state_t;

  localparam int DEFAULT_ROWS = 8;
  localparam int DEFAULT_COLS = 8;

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered frame store: active frame being scanned plus a shadow frame waiting
// for the next frame boundary, with a bit-select read port.
module led_frame_buffer
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  localparam int FRAME_W = ROWS * COLS,
  localparam int IDX_W = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_active,
  input  logic               load_shadow,
  input  logic               swap,
  input  logic               discard,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_bit
);

  logic [FRAME_W-1:0] active_q;
  logic [FRAME_W-1:0] shadow_q;
  logic [FRAME_W-1:0] active_d;
  logic               pending_q;

  // The read port looks at the frame that will be active after this edge, so the
  // scanner can register the first bit of a freshly loaded or swapped frame.
  always_comb begin
    active_d = active_q;
    if (load_active) begin
      active_d = frame_in;
    end else if (swap && pending_q) begin
      active_d = shadow_q;
    end
  end

  assign rd_bit = active_d[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      active_q <= active_d;
      if (load_shadow) begin
        shadow_q <= frame_in;
      end
      // A capture on the boundary edge survives a swap but not a return to idle.
      if (discard) begin
        pending_q <= 1'b0;
      end else if (load_shadow) begin
        pending_q <= 1'b1;
      end else if (swap) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-by-row serialiser for a ROWS x COLS LED matrix driving a 74HC595-style column chain.
// Define LED_MATRIX_BLANK_EN to add the oe_n_out anti-ghosting blanking output.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int COLS = DEFAULT_COLS,
  localparam int FRAME_W = ROWS * COLS,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS),
  localparam int IDX_W = $clog2(FRAME_W)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               tick_in,
  input  logic               start_in,
  input  logic               continuous_in,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               sclk_out,
  output logic               data_out,
  output logic               latch_out,
`ifdef LED_MATRIX_BLANK_EN
  output logic               oe_n_out,
`endif
  output logic [ROWS-1:0]    row_sel_out
);

  scan_state_t      state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_bit;
  logic             load_active;
  logic             load_shadow;
  logic             frame_end;
  logic             swap;
  logic             discard;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  assign load_active = (state == IDLE) && start_in;
  assign load_shadow = (state != IDLE) && start_in;
  assign frame_end   = (state == LATCH) && tick_in && (row == LAST_ROW);
  assign swap        = frame_end && continuous_in;
  assign discard     = frame_end && !continuous_in;

  // Address of the pixel that becomes current if the FSM advances on this edge.
  always_comb begin
    rd_row = row;
    rd_col = col;
    case (state)
      IDLE: begin
        rd_row = '0;
        rd_col = LAST_COL;
      end
      SHIFT_HI: begin
        if (col != '0) rd_col = col - 1'b1;
      end
      LATCH: begin
        rd_col = LAST_COL;
        rd_row = (row == LAST_ROW) ? '0 : row + 1'b1;
      end
      default: ;
    endcase
    rd_idx = IDX_W'(int'(rd_row) * COLS + int'(rd_col));
  end

  led_frame_buffer #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_frame_buffer (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .load_active (load_active),
    .load_shadow (load_shadow),
    .swap        (swap),
    .discard     (discard),
    .frame_in    (frame_in),
    .rd_idx      (rd_idx),
    .rd_bit      (rd_bit)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      sclk_out    <= 1'b0;
      data_out    <= 1'b0;
      latch_out   <= 1'b0;
      row_sel_out <= '0;
`ifdef LED_MATRIX_BLANK_EN
      oe_n_out    <= 1'b1;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= SHIFT_LO;
            busy_out <= 1'b1;
            row      <= '0;
            col      <= LAST_COL;
            sclk_out <= 1'b0;
            data_out <= rd_bit;
`ifdef LED_MATRIX_BLANK_EN
            oe_n_out <= 1'b1;
`endif
          end
        end
        SHIFT_LO: begin
          if (tick_in) begin
            state    <= SHIFT_HI;
            sclk_out <= 1'b1;
`ifdef LED_MATRIX_BLANK_EN
            oe_n_out <= 1'b1;
`endif
          end
        end
        SHIFT_HI: begin
          if (tick_in) begin
            sclk_out <= 1'b0;
            if (col == '0) begin
              state       <= LATCH;
              latch_out   <= 1'b1;
              data_out    <= 1'b0;
              row_sel_out <= ROWS'(1) << row;
            end else begin
              state    <= SHIFT_LO;
              col      <= col - 1'b1;
              data_out <= rd_bit;
            end
          end
        end
        LATCH: begin
          if (tick_in) begin
            latch_out <= 1'b0;
            col       <= LAST_COL;
`ifdef LED_MATRIX_BLANK_EN
            oe_n_out  <= 1'b0;
`endif
            if (row != LAST_ROW) begin
              state    <= SHIFT_LO;
              row      <= row + 1'b1;
              data_out <= rd_bit;
            end else if (continuous_in) begin
              state    <= SHIFT_LO;
              row      <= '0;
              data_out <= rd_bit;
            end else begin
              state    <= IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: 8x8 main instance plus a 4x16 instance.
module tb_led_matrix_scanner;

  localparam int EV_BIT   = 0;
  localparam int EV_LATCH = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        start_in = 1'b0;
  logic        start2 = 1'b0;
  logic        continuous_in = 1'b0;
  logic [63:0] frame_in = '0;

  logic       busy, done, sclk, data, latch;
  logic [7:0] row_sel;
  logic       busy2, done2, sclk2, data2, latch2;
  logic [3:0] row_sel2;
`ifdef LED_MATRIX_BLANK_EN
  logic oe_n, oe_n2;
`endif

  ev_t exp_q[$];
  ev_t exp2_q[$];
  int  checks = 0;
  int  errors = 0;
  int  events_seen = 0;
  int  tick_cnt = 0;
  int  tick_cnt2 = 0;
  int  latch_hi = 0;
  int  tick_div = 0;
  logic prev_sclk = 1'b0, prev_latch = 1'b0, prev_latch2 = 1'b0;

  led_matrix_scanner #(.ROWS(8), .COLS(8)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .tick_in       (tick_in),
    .start_in      (start_in),
    .continuous_in (continuous_in),
    .frame_in      (frame_in),
    .busy_out      (busy),
    .done_out      (done),
    .sclk_out      (sclk),
    .data_out      (data),
    .latch_out     (latch),
`ifdef LED_MATRIX_BLANK_EN
    .oe_n_out      (oe_n),
`endif
    .row_sel_out   (row_sel)
  );

  led_matrix_scanner #(.ROWS(4), .COLS(16)) dut2 (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .tick_in       (tick_in),
    .start_in      (start2),
    .continuous_in (1'b0),
    .frame_in      (frame_in),
    .busy_out      (busy2),
    .done_out      (done2),
    .sclk_out      (sclk2),
    .data_out      (data2),
    .latch_out     (latch2),
`ifdef LED_MATRIX_BLANK_EN
    .oe_n_out      (oe_n2),
`endif
    .row_sel_out   (row_sel2)
  );

  always #5 clk = ~clk;

  // Divider stand-in: one tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tick_in = (tick_div == 3);
    tick_div = (tick_div + 1) % 4;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt = 0;
      tick_cnt2 = 0;
    end else begin
      if (tick_in && busy) tick_cnt++;
      if (tick_in && busy2) tick_cnt2++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic expect_event(input int kind, input int value, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected event actual=%0d required=none", name, value);
    end else begin
      e = exp_q.pop_front();
      events_seen++;
      checkOutput(name, {kind, value}, {e.kind, e.value});
    end
  endtask

  task automatic expect_event2(input int kind, input int value, input string name);
    ev_t e;
    if (exp2_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected event actual=%0d required=none", name, value);
    end else begin
      e = exp2_q.pop_front();
      checkOutput(name, {kind, value}, {e.kind, e.value});
    end
  endtask

  // Monitor: bits on sclk rising edges, row select on latch rising edges, tick count at done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sclk && !prev_sclk) expect_event(EV_BIT, int'(data), "data_bit");
      if (latch && !prev_latch) expect_event(EV_LATCH, int'(row_sel), "row_sel");
      if (latch) latch_hi++;
      if (!latch && prev_latch) begin
        checkOutput("latch_width_clks", 64'(latch_hi), 64'd4);
        latch_hi = 0;
      end
      if (done) begin
        expect_event(EV_DONE, tick_cnt, "done_ticks");
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        tick_cnt = 0;
      end
      if (latch2 && !prev_latch2) expect_event2(EV_LATCH, int'(row_sel2), "row_sel2");
      if (done2) begin
        expect_event2(EV_DONE, tick_cnt2, "done2_ticks");
        tick_cnt2 = 0;
      end
    end else begin
      latch_hi = 0;
    end
    prev_sclk = sclk;
    prev_latch = latch;
    prev_latch2 = latch2;
  end

  task automatic push_row(input logic [7:0] bits, input int r);
    for (int c = 7; c >= 0; c--) exp_q.push_back('{EV_BIT, int'(bits[c])});
    exp_q.push_back('{EV_LATCH, 1 << r});
  endtask

  task automatic push_frame(input logic [63:0] f);
    for (int r = 0; r < 8; r++) push_row(f[r*8 +: 8], r);
  endtask

  task automatic applyStimulus(input logic [63:0] f, input bit second);
    @(negedge clk);
    frame_in = f;
    if (second) start2 = 1'b1;
    else start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget);
    int n = 0;
    while (events_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (events_seen < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_events timeout actual=%0d required=%0d", events_seen, target);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0 || busy || busy2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout actual=%0d required=0", exp_q.size() + exp2_q.size());
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int base;
    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_sclk", 64'(sclk), 64'd0);
    checkOutput("reset_data", 64'(data), 64'd0);
    checkOutput("reset_latch", 64'(latch), 64'd0);
    checkOutput("reset_row_sel", 64'(row_sel), 64'd0);
    rst_n = 1'b1;

    $display("[TB] single-shot 8x8 frame");
    push_row(8'h2B, 0);
    for (int r = 1; r < 7; r++) push_row(8'h00, r);
    push_row(8'h81, 7);
    exp_q.push_back('{EV_DONE, 136});
    applyStimulus(64'h8100_0000_0000_002B, 1'b0);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    wait_drain(2000);
    checkOutput("idle_row_sel", 64'(row_sel), 64'h80);

    $display("[TB] reset in row 3");
    base = events_seen;
    push_frame(64'hF0E1_D2C3_B4A5_9687);
    applyStimulus(64'hF0E1_D2C3_B4A5_9687, 1'b0);
    wait_events(base + 30, 2000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_sclk", 64'(sclk), 64'd0);
    checkOutput("async_data", 64'(data), 64'd0);
    checkOutput("async_latch", 64'(latch), 64'd0);
    checkOutput("async_row_sel", 64'(row_sel), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    push_frame(64'h0123_4567_89AB_CDEF);
    exp_q.push_back('{EV_DONE, 136});
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0);
    wait_drain(2000);

    $display("[TB] continuous with shadow update");
    base = events_seen;
    continuous_in = 1'b1;
    push_frame(64'h0102_0408_1020_4080);
    push_frame(64'hAA55_AA55_00FF_FF00);
    exp_q.push_back('{EV_DONE, 272});
    applyStimulus(64'h0102_0408_1020_4080, 1'b0);
    wait_events(base + 20, 2000);
    applyStimulus(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    applyStimulus(64'hAA55_AA55_00FF_FF00, 1'b0);
    wait_events(base + 82, 2000);
    continuous_in = 1'b0;
    wait_drain(3000);

    $display("[TB] single-shot with start while busy");
    base = events_seen;
    push_frame(64'h3C3C_3C3C_C3C3_C3C3);
    exp_q.push_back('{EV_DONE, 136});
    applyStimulus(64'h3C3C_3C3C_C3C3_C3C3, 1'b0);
    wait_events(base + 30, 2000);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_drain(2000);
    repeat (20) @(negedge clk);
    checkOutput("idle_hold_row_sel", 64'(row_sel), 64'h80);
    checkOutput("idle_busy", 64'(busy), 64'd0);

    $display("[TB] 4x16 frame");
    for (int r = 0; r < 4; r++) exp2_q.push_back('{EV_LATCH, 1 << r});
    exp2_q.push_back('{EV_DONE, 132});
    applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b1);
    wait_drain(2000);
    checkOutput("idle_row_sel2", 64'(row_sel2), 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised successor of the single-byte serial LED shifter.
- Captures a full ROWS x COLS frame and serialises it row by row to an external shift-register/latch column driver (74HC595-style): data, shift clock, latch strobe.
- Drives one-hot row select; supports single-shot or continuous refresh with double-buffered frame update.
- Sits between the frequency divider (supplies tick_in) and the matrix pins.

Parameters:
- ROWS, 8, number of matrix rows (>=2).
- COLS, 8, number of columns, i.e. bits shifted per row (>=2).
- Localparams: FRAME_W = ROWS*COLS; ROW_W = $clog2(ROWS); COL_W = $clog2(COLS).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- tick_in  input  1  single-cycle enable from the divider; all output-pin timing advances only on tick_in.
- start_in  input  1  request: capture frame_in.
- continuous_in  input  1  1 = refresh continuously, 0 = single frame.
- frame_in  input  FRAME_W  pixel data; row r, column c = frame_in[r*COLS+c].
- busy_out  output  1  scan in progress.
- done_out  output  1  one clk pulse when a single-shot frame (or the final continuous frame) completes.
- sclk_out  output  1  column shift clock.
- data_out  output  1  column serial data.
- latch_out  output  1  column latch strobe.
- row_sel_out  output  ROWS  one-hot active row.

Behaviour:
- Reset: all outputs 0, FSM IDLE, both buffers 0, counters 0. Reset mid-scan aborts immediately; no done_out.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: start_in=1 captures frame_in into the active buffer on that clk edge (no tick needed); busy_out=1 next cycle; row=0, col=COLS-1; enter SHIFT_LO.
- SHIFT_LO: sclk_out=0, data_out = buf[row*COLS+col]. On tick go to SHIFT_HI.
- SHIFT_HI: sclk_out=1, data held. On tick:
  - if col==0, go to LATCH;
  - else col-1 and back to SHIFT_LO.
- Bit order is MSB-first (column COLS-1 first).
- LATCH: latch_out=1, sclk_out=0, and row_sel_out=1<<row from entry. On tick, latch_out=0:
  - if row<ROWS-1: row+1, col=COLS-1, go to SHIFT_LO;
  - else end of frame.
- End of frame:
  - if continuous_in=1: swap in the shadow buffer if pending, row=0, continue with SHIFT_LO;
  - else done_out pulses for 1 clk, busy_out=0, go to IDLE.
- row_sel_out holds its last value in IDLE; the display keeps the last row lit.
- Frame timing: ROWS*(2*COLS+1) ticks (136 for 8x8). No counter wrap beyond ROWS-1/0.
- start_in while busy: frame_in captured into the shadow buffer, pending flag set. Swapped at end of frame only if continuous; otherwise discarded when going to IDLE. A later start_in overwrites the shadow.
- start_in in the same cycle as the end-of-frame edge: treated as shadow capture; swap takes effect on the next frame boundary.
- tick_in and start_in in the same IDLE cycle: capture only; the first tick is consumed by SHIFT_LO.
- continuous_in is sampled only at end of frame; dropping it finishes the current frame cleanly.

Optional Feature:
- Macro: LED_MATRIX_BLANK_EN.
- Defined: adds output oe_n_out (1 bit, reset 1).
  - oe_n_out=1 (display blanked) from SHIFT_LO of each row through LATCH.
  - oe_n_out=0 on the tick leaving LATCH until the next row's shifting begins; also 0 in IDLE after a completed frame.
  - Prevents ghosting.
- Undefined: port absent; no blanking logic.

Decomposition:
- Shared package led_matrix_pkg:
  - state encoding (IDLE=2'd0, SHIFT_LO=2'd1, SHIFT_HI=2'd2, LATCH=2'd3);
  - default ROWS/COLS constants.
- One sub-module: led_frame_buffer (active plus shadow FRAME_W registers, pending flag, swap/discard control, bit-select read port).
- FSM and counters stay in the top level.

Test Plan:
- 8x8, tick_in every 4 clks, continuous_in=0, start_in with frame_in=64'h8100_0000_0000_002B:
  - row 0 serial stream 0,0,1,0,1,0,1,1 sampled on sclk_out rising edges;
  - latch_out high for 1 tick, row_sel_out=8'h01;
  - row 7 stream 1,0,0,0,0,0,0,1;
  - done_out after exactly 136 ticks; busy_out drops.
- Reset asserted in row 3 mid-shift: all outputs 0 asynchronously, no done_out; restarting scans from row 0.
- Continuous mode, start_in with frame A then frame B mid-frame: A completes unchanged, next frame shows B, no done_out; dropping continuous_in gives done_out after the current frame.
- Single-shot with start_in while busy: the second frame is discarded; after done_out, IDLE holds row_sel_out=8'h80.
- Non-square ROWS=4, COLS=16: 4*33=132 ticks per frame, row_sel_out walks 1,2,4,8.
- LED_MATRIX_BLANK_EN defined: oe_n_out=1 during every shift/latch, 0 between rows; reset value 1.
